// File: rtl/logic_combine_pipe_if.sv
// Operand/result handshake bundle for logic_combine_pipe.
// The master side is the surrounding environment; the slave side is the pipeline.
interface logic_combine_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, mode, in_valid, out_ready,
        input  in_ready, y, out_valid
    );

    modport slave (
        input  a, b, mode, in_valid, out_ready,
        output in_ready, y, out_valid
    );
endinterface

// File: rtl/logic_combine_pipe.sv
// Runtime-selected bitwise combine of two operands, carried through a DEPTH-stage
// stallable valid/ready pipeline, with a saturating count of delivered nonzero results.
module logic_combine_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_combine_pipe_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     nz_cnt
);
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] free_s;
    logic             chain_full_s;
    logic             fire_s;
    logic [CNT_W-1:0] cnt_r;

    function automatic logic [WIDTH-1:0] combine(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [1:0]       sel
    );
        logic [WIDTH-1:0] res;
        case (sel)
            2'b00:   res = op_a & op_b;
            2'b01:   res = op_a | op_b;
            2'b10:   res = op_a ^ op_b;
            2'b11:   res = op_a & ~op_b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // A stage is free unless it and every stage ahead of it are full while the head stalls.
    always_comb begin
        free_s       = '0;
        chain_full_s = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain_full_s = chain_full_s & valid_r[k];
            free_s[k]    = !chain_full_s || bus.out_ready;
        end
    end

    assign bus.in_ready  = free_s[0];
    assign bus.y         = data_r[DEPTH-1];
    assign bus.out_valid = valid_r[DEPTH-1];
    assign fire_s        = valid_r[DEPTH-1] && bus.out_ready && (data_r[DEPTH-1] != '0);
    assign nz_cnt        = cnt_r;

    // Pipeline advance: each free stage takes its predecessor's beat, stage 0 takes the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            if (free_s[0]) begin
                valid_r[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_r[0] <= combine(bus.a, bus.b, bus.mode);
                end
            end
            // Data only moves with a valid beat so an idle head keeps its last value.
            for (int k = 1; k < DEPTH; k++) begin
                if (free_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    if (valid_r[k-1]) begin
                        data_r[k] <= data_r[k-1];
                    end
                end
            end
        end
    end

    // Nonzero delivery counter: clear has priority, increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (cnt_clr) begin
            cnt_r <= '0;
        end else if (fire_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end
endmodule
